// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: instruction memory port, redirect input and the IF/ID register outputs.
// master = fetch unit side, slave = memory/decode/control side.
interface ifetch_unit_if;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        id_exc_en;
  logic [3:0]  id_exc_code;
  logic [63:0] id_exc_val;

  modport master (
    output pc_addr, id_valid, id_instr, id_pc, id_exc_en, id_exc_code, id_exc_val,
    input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    input  redirect_en, redirect_pc, id_ready
  );

  modport slave (
    input  pc_addr, id_valid, id_instr, id_pc, id_exc_en, id_exc_code, id_exc_val,
    output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
    output redirect_en, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch with IF/ID register: one-cycle fetch latency, one instr/cycle, holds while decode stalls.
// A fetch fault issues a NOP carrying the exception, then fetching halts until a redirect.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);
  typedef enum logic {RUN, WAIT_TRAP} state_t;

  state_t      state;
  logic [63:0] pc;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [63:0] pc_q;
  logic        exc_en_q;
  logic [3:0]  exc_code_q;
  logic [63:0] exc_val_q;

  logic load;
  logic misaligned;
  logic fault;

  assign load       = !valid_q || bus.id_ready;
  assign misaligned = (pc[1:0] != 2'b00);
  assign fault      = misaligned || bus.imem_exc_en;

  assign bus.pc_addr     = pc;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc       = pc_q;
  assign bus.id_exc_en   = exc_en_q;
  assign bus.id_exc_code = exc_code_q;
  assign bus.id_exc_val  = exc_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 64'd0;
      exc_en_q   <= 1'b0;
      exc_code_q <= 4'd0;
      exc_val_q  <= 64'd0;
    end else if (bus.redirect_en) begin
      // Whatever sits in IF/ID this cycle is squashed; target is fetched next cycle.
      state    <= RUN;
      pc       <= bus.redirect_pc;
      valid_q  <= 1'b0;
      exc_en_q <= 1'b0;
    end else if (load) begin
      case (state)
        RUN: begin
          valid_q <= 1'b1;
          pc_q    <= pc;
          if (fault) begin
            instr_q    <= NOP_INSTR;
            exc_en_q   <= 1'b1;
            exc_code_q <= misaligned ? 4'd0 : bus.imem_exc_code;
            exc_val_q  <= misaligned ? pc : bus.imem_exc_val;
            state      <= WAIT_TRAP;
          end else begin
            instr_q    <= bus.imem_instr;
            exc_en_q   <= 1'b0;
            exc_code_q <= 4'd0;
            exc_val_q  <= 64'd0;
            pc         <= pc + 64'd4;
          end
        end
        WAIT_TRAP: begin
          valid_q    <= 1'b0;
          exc_en_q   <= 1'b0;
          exc_code_q <= 4'd0;
          exc_val_q  <= 64'd0;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench: each reset/redirect queues the instruction stream a fetch from that PC must deliver;
// a negedge monitor compares the IF/ID register against the queue head and pops on acceptance.
module tb_ifetch_unit;
  localparam logic [63:0] RESET_PC  = 64'h0;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  ifetch_unit_if bus();

  ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_instr(input logic [63:0] a);
    return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
  endfunction
  function automatic logic mem_fault(input logic [63:0] a);
    return (a[8] && a[5:2] == 4'hB) || a == 64'h40000 || a == 64'h102;
  endfunction
  function automatic logic [3:0] mem_code(input logic [63:0] a);
    return {1'b0, a[12:10]} + 4'd1;
  endfunction

  always_comb begin
    bus.imem_instr    = mem_instr(bus.pc_addr);
    bus.imem_exc_en   = mem_fault(bus.pc_addr);
    bus.imem_exc_code = mem_code(bus.pc_addr);
    bus.imem_exc_val  = bus.pc_addr;
  end

  entry_t      q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        fault_seen = 1'b0;
  logic [63:0] hold_pc = 64'd0;
  logic        prev_rst = 1'b0;
  logic        prev_redir = 1'b0;
  logic [63:0] prev_target = 64'd0;
  logic        started = 1'b0;

  // Expected stream from PC p: sequential words until the first faulting one.
  task automatic gen_stream(input logic [63:0] p);
    entry_t e;
    logic [63:0] a;
    q.delete();
    fault_seen = 1'b0;
    for (int k = 0; k < 256; k++) begin
      a = p + 64'(4 * k);
      e.pc = a;
      if (a[1:0] != 2'b00 || mem_fault(a)) begin
        e.instr  = NOP_INSTR;
        e.exc_en = 1'b1;
        e.code   = (a[1:0] != 2'b00) ? 4'd0 : mem_code(a);
        e.val    = a;
        q.push_back(e);
        break;
      end
      e.instr  = mem_instr(a);
      e.exc_en = 1'b0;
      e.code   = 4'd0;
      e.val    = 64'd0;
      q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (prev_rst) begin
      check("rst_valid", 64'(bus.id_valid), 64'd0);
      check("rst_instr", 64'(bus.id_instr), 64'(NOP_INSTR));
      check("rst_id_pc", bus.id_pc, 64'd0);
      check("rst_exc_en", 64'(bus.id_exc_en), 64'd0);
      check("rst_exc_code", 64'(bus.id_exc_code), 64'd0);
      check("rst_exc_val", bus.id_exc_val, 64'd0);
      check("rst_pc_addr", bus.pc_addr, RESET_PC);
    end else if (prev_redir) begin
      check("redir_bubble_valid", 64'(bus.id_valid), 64'd0);
      check("redir_exc_en", 64'(bus.id_exc_en), 64'd0);
      check("redir_pc_addr", bus.pc_addr, prev_target);
    end else if (started && !rst && !bus.redirect_en) begin
      if (q.size() > 0) begin
        check("stream_valid", 64'(bus.id_valid), 64'd1);
        if (bus.id_valid) begin
          check("id_pc", bus.id_pc, q[0].pc);
          check("id_instr", 64'(bus.id_instr), 64'(q[0].instr));
          check("id_exc_en", 64'(bus.id_exc_en), 64'(q[0].exc_en));
          check("id_exc_code", 64'(bus.id_exc_code), 64'(q[0].code));
          check("id_exc_val", bus.id_exc_val, q[0].val);
          check("pc_addr_ahead", bus.pc_addr, q[0].exc_en ? q[0].pc : q[0].pc + 64'd4);
        end
      end else if (fault_seen) begin
        check("trap_valid", 64'(bus.id_valid), 64'd0);
        check("trap_exc_en", 64'(bus.id_exc_en), 64'd0);
        check("trap_pc_held", bus.pc_addr, hold_pc);
      end
    end
    if (started && !rst && !bus.redirect_en && bus.id_valid && bus.id_ready && q.size() > 0 && !prev_rst && !prev_redir) begin
      if (q[0].exc_en) begin
        fault_seen = 1'b1;
        hold_pc    = q[0].pc;
      end
      void'(q.pop_front());
    end else if (started && !rst && !bus.redirect_en && bus.id_valid && bus.id_ready && q.size() > 0) begin
      void'(q.pop_front());
    end
    prev_rst    = rst;
    prev_redir  = bus.redirect_en;
    prev_target = bus.redirect_pc;
  end

  task automatic step(input logic r, input logic re, input logic [63:0] t, input logic rdy);
    @(posedge clk);
    #1;
    rst             = r;
    bus.redirect_en = re;
    bus.redirect_pc = t;
    bus.id_ready    = rdy;
    started         = 1'b1;
    if (r) gen_stream(RESET_PC);
    else if (re) gen_stream(t);
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    int sel;
    sel = $urandom_range(0, 19);
    t = 64'($urandom_range(0, 1023)) << 2;
    if (sel == 0) t = 64'hFFFF_FFFF_FFFF_FFF0;
    else if (sel < 3) t = t | 64'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    int r;
    rst             = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 64'd0;
    bus.id_ready    = 1'b1;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    step(0, 1, 64'h100, 0);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 64'h40000, 1);
    repeat (4) step(0, 0, 0, 1);
    step(0, 1, 64'h40000, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 64'h102, 1);
    repeat (3) step(0, 0, 0, 1);
    step(1, 1, 64'h200, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
    repeat (4) step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 2, r >= 1 && r < 9, pick_target(), $urandom_range(0, 3) != 0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
